// File: rtl/sprite_line_evaluator_if.sv
// Port bundle between the sprite line evaluator, the VGA timing source,
// the OAM RAM and the object engine.
interface sprite_line_evaluator_if #(
    parameter int AW    = 6,
    parameter int IW    = 3,
    parameter int CNT_W = 4
);
    // No valid/ready pairs: x/y advance every clock, OAM returns data one
    // cycle after oam_addr, and the cache read is combinational and valid in any cycle.
    logic [9:0]       x;
    logic [9:0]       y;
    logic [AW-1:0]    oam_addr;
    logic [31:0]      oam_data;
    logic [IW-1:0]    cache_idx;
    logic [31:0]      cache_entry;
    logic [CNT_W-1:0] sprite_count;
    logic             overflow;
    logic             eval_busy;
    logic [1:0]       dbg_state;

    modport slave (
        input  x, y, oam_data, cache_idx,
        output oam_addr, cache_entry, sprite_count, overflow, eval_busy, dbg_state
    );

    modport master (
        output x, y, oam_data, cache_idx,
        input  oam_addr, cache_entry, sprite_count, overflow, eval_busy, dbg_state
    );
endinterface

// File: rtl/sprite_line_evaluator.sv
// Scans OAM during hblank for sprites on the next line, fills a back cache,
// and swaps it to the front cache at end of line.
module sprite_line_evaluator #(
    parameter int OAM_DEPTH    = 64,
    parameter int CACHE_DEPTH  = 8,
    parameter int TILE_HEIGHT  = 32,
    parameter int H_EVAL_START = 640,
    parameter int H_TOTAL      = 800,
    parameter int V_TOTAL      = 525
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sprite_line_evaluator_if.slave  bus
);
    localparam int AW = $clog2(OAM_DEPTH);
    localparam int IW = $clog2(CACHE_DEPTH);
    localparam int NW = $clog2(CACHE_DEPTH + 1);

    generate
        if (OAM_DEPTH + 3 > H_TOTAL - 1 - H_EVAL_START) begin : g_bad_timing
            $error("scan does not fit between H_EVAL_START and end of line");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic            rd_valid_q;
    logic            busy_q;
    logic [9:0]      target_y_q;
    logic [31:0]     back_q  [CACHE_DEPTH];
    logic [31:0]     front_q [CACHE_DEPTH];
    logic [NW-1:0]   back_cnt_q, front_cnt_q;
    logic            back_ovf_q, front_ovf_q;

    logic            trig, swap, hit;
    logic [9:0]      pos_y;
    logic [10:0]     pos_y_end;

    assign trig      = (state_q == S_IDLE) && (bus.x == 10'(H_EVAL_START));
    assign swap      = (bus.x == 10'(H_TOTAL - 1));
    assign pos_y     = bus.oam_data[15:6];
    // 11-bit end so sprites near the bottom of the 10-bit range never wrap to line 0
    assign pos_y_end = {1'b0, pos_y} + 11'(TILE_HEIGHT);
    assign hit       = bus.oam_data[31] && (target_y_q >= pos_y)
                       && ({1'b0, target_y_q} < pos_y_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (trig) state_d = S_SCAN;
            S_SCAN:  if (addr_q == AW'(OAM_DEPTH - 1)) state_d = S_DRAIN;
            // Leave only once the entry read on the last SCAN cycle has been consumed
            S_DRAIN: if (!rd_valid_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            rd_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            target_y_q  <= '0;
            back_cnt_q  <= '0;
            front_cnt_q <= '0;
            back_ovf_q  <= 1'b0;
            front_ovf_q <= 1'b0;
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                back_q[i]  <= '0;
                front_q[i] <= '0;
            end
        end else begin
            rd_valid_q <= (state_q == S_SCAN);

            if (trig) begin
                target_y_q <= (bus.y == 10'(V_TOTAL - 1)) ? 10'd0 : bus.y + 10'd1;
                addr_q     <= '0;
                busy_q     <= 1'b1;
                back_cnt_q <= '0;
                back_ovf_q <= 1'b0;
                for (int i = 0; i < CACHE_DEPTH; i++) back_q[i] <= '0;
            end

            if (state_q == S_SCAN && addr_q != AW'(OAM_DEPTH - 1))
                addr_q <= addr_q + AW'(1);

            // OAM order is preserved: each hit takes the next free slot
            if (rd_valid_q && hit) begin
                if (back_cnt_q < NW'(CACHE_DEPTH)) begin
                    back_q[back_cnt_q[IW-1:0]] <= bus.oam_data;
                    back_cnt_q                 <= back_cnt_q + NW'(1);
                end else begin
                    back_ovf_q <= 1'b1;
                end
            end

            if (state_q == S_DRAIN && !rd_valid_q)
                busy_q <= 1'b0;

            if (swap) begin
                front_cnt_q <= back_cnt_q;
                front_ovf_q <= back_ovf_q;
                for (int i = 0; i < CACHE_DEPTH; i++) front_q[i] <= back_q[i];
            end
        end
    end

    assign bus.oam_addr     = addr_q;
    assign bus.cache_entry  = front_q[bus.cache_idx];
    assign bus.sprite_count = front_cnt_q;
    assign bus.overflow     = front_ovf_q;
    assign bus.eval_busy    = busy_q;
    assign bus.dbg_state    = state_q;
endmodule
